// File: rtl/dc_index_extractor_arb_pkg.sv
// Shared types and default geometry for the DRAM-cache index extractor/arbiter.
// The descriptor struct describes the default configuration; the top packs the same field order.
package dc_pkg;

  localparam int DC_ID_W     = 16;
  localparam int DC_ADDR_W   = 64;
  localparam int DC_OFFSET_W = 6;
  localparam int DC_INDEX_W  = 20;
  localparam int DC_SEQ_W    = 8;

  localparam int TAG_W  = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W;
  localparam int DESC_W = DC_SEQ_W + 1 + DC_ID_W + TAG_W + DC_INDEX_W + DC_OFFSET_W;

  typedef struct packed {
    logic [DC_SEQ_W-1:0]    seq;
    logic                   is_wr;
    logic [DC_ID_W-1:0]     id;
    logic [TAG_W-1:0]       tag;
    logic [DC_INDEX_W-1:0]  index;
    logic [DC_OFFSET_W-1:0] offset;
  } dc_desc_t;

  typedef enum logic {
    ARB_RD_PRIO = 1'b0,
    ARB_RR      = 1'b1
  } arb_mode_e;

  typedef enum logic {
    RR_READ  = 1'b0,
    RR_WRITE = 1'b1
  } rr_side_e;

  // tag + index + offset always spans the full address, so only the address width matters.
  function automatic int dc_desc_width(int seq_w, int id_w, int addr_w);
    return seq_w + 1 + id_w + addr_w;
  endfunction

endpackage

// File: rtl/dc_index_extractor_arb_if.sv
// Host AR/AW request ports, tag-array AR issue port and tag-FIFO write port as one bundle.
// slave is the extractor's view, master is the surrounding system's view.
interface dc_index_extractor_arb_if #(
  parameter int ID_W   = dc_pkg::DC_ID_W,
  parameter int ADDR_W = dc_pkg::DC_ADDR_W,
  parameter int SEQ_W  = dc_pkg::DC_SEQ_W,
  parameter int DESC_W = dc_pkg::DESC_W
);

  logic [ID_W-1:0]   arid_i;
  logic [ADDR_W-1:0] araddr_i;
  logic              arvalid_i;
  logic              arready_o;

  logic [ID_W-1:0]   awid_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic              awvalid_i;
  logic              awready_o;

  logic [SEQ_W-1:0]  arid_o;
  logic [ADDR_W-1:0] araddr_o;
  logic              arvalid_o;
  logic              arready_i;

  logic              tag_fifo_afull_i;
  logic              tag_fifo_wren_o;
  logic [DESC_W-1:0] tag_fifo_data_o;

  modport slave (
    input  arid_i, araddr_i, arvalid_i,
    input  awid_i, awaddr_i, awvalid_i,
    input  arready_i, tag_fifo_afull_i,
    output arready_o, awready_o,
    output arid_o, araddr_o, arvalid_o,
    output tag_fifo_wren_o, tag_fifo_data_o
  );

  modport master (
    output arid_i, araddr_i, arvalid_i,
    output awid_i, awaddr_i, awvalid_i,
    output arready_i, tag_fifo_afull_i,
    input  arready_o, awready_o,
    input  arid_o, araddr_o, arvalid_o,
    input  tag_fifo_wren_o, tag_fifo_data_o
  );

endinterface

// File: rtl/dc_index_extractor_arb_rr_arb2.sv
// Two-requester (read/write) arbiter: fixed read priority or round robin.
// The round-robin pointer only moves when both sides contend and the winner is accepted.
module dc_rr_arb2
  import dc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  arb_mode_e mode_i,
  input  logic      req_rd_i,
  input  logic      req_wr_i,
  input  logic      accept_i,
  output logic      grant_rd_o,
  output logic      grant_wr_o
);

  rr_side_e ptr_q;
  rr_side_e ptr_d;
  logic     contended;

  assign contended = req_rd_i & req_wr_i;

  // NOTE: every output of this block gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    grant_rd_o = 1'b0;
    grant_wr_o = 1'b0;
    ptr_d      = ptr_q;

    if (contended) begin
      if (mode_i == ARB_RR && ptr_q == RR_WRITE) begin
        grant_wr_o = 1'b1;
      end else begin
        grant_rd_o = 1'b1;
      end
      if (accept_i && mode_i == ARB_RR) begin
        ptr_d = (ptr_q == RR_WRITE) ? RR_READ : RR_WRITE;
      end
    end else begin
      grant_rd_o = req_rd_i;
      grant_wr_o = req_wr_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= RR_READ;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dc_index_extractor_arb.sv
// Arbitrates host AR/AW requests, splits the address into tag/index/offset, issues a
// tag-array read and writes a lookup descriptor {seq, is_wr, id, tag, index, offset}.
module dc_index_extractor_arb
  import dc_pkg::*;
#(
  parameter int                ID_W      = DC_ID_W,
  parameter int                ADDR_W    = DC_ADDR_W,
  parameter int                OFFSET_W  = DC_OFFSET_W,
  parameter int                INDEX_W   = DC_INDEX_W,
  parameter int                SEQ_W     = DC_SEQ_W,
  parameter int                SET_BYTES = 64,
  parameter logic [ADDR_W-1:0] TAG_BASE  = '0,
  parameter bit                ARB_MODE  = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  dc_index_extractor_arb_if.slave bus
);

  localparam int TAG_BITS  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int DESC_BITS = dc_desc_width(SEQ_W, ID_W, ADDR_W);

  logic can_acc;
  logic grant_rd;
  logic grant_wr;
  logic acc_rd;
  logic acc_wr;
  logic accept;

  logic [ADDR_W-1:0]   sel_addr;
  logic [ID_W-1:0]     sel_id;
  logic [TAG_BITS-1:0] f_tag;
  logic [INDEX_W-1:0]  f_index;
  logic [OFFSET_W-1:0] f_offset;
  logic [ADDR_W-1:0]   tag_addr;
  logic [DESC_BITS-1:0] desc;

  logic                 arvalid_q, arvalid_d;
  logic [SEQ_W-1:0]     arid_q,    arid_d;
  logic [ADDR_W-1:0]    araddr_q,  araddr_d;
  logic                 wren_q,    wren_d;
  logic [DESC_BITS-1:0] data_q,    data_d;
  logic [SEQ_W-1:0]     seq_q,     seq_d;

  // A held request that is being taken this cycle frees the output register.
  assign can_acc = (~arvalid_q | bus.arready_i) & ~bus.tag_fifo_afull_i;

  dc_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .mode_i     (arb_mode_e'(ARB_MODE)),
    .req_rd_i   (bus.arvalid_i),
    .req_wr_i   (bus.awvalid_i),
    .accept_i   (can_acc),
    .grant_rd_o (grant_rd),
    .grant_wr_o (grant_wr)
  );

  assign acc_rd = can_acc & grant_rd;
  assign acc_wr = can_acc & grant_wr;
  assign accept = acc_rd | acc_wr;

  assign bus.arready_o = acc_rd;
  assign bus.awready_o = acc_wr;

  assign sel_addr = grant_wr ? bus.awaddr_i : bus.araddr_i;
  assign sel_id   = grant_wr ? bus.awid_i   : bus.arid_i;

  assign f_offset = sel_addr[OFFSET_W-1:0];
  assign f_index  = sel_addr[OFFSET_W +: INDEX_W];
  assign f_tag    = sel_addr[ADDR_W-1 -: TAG_BITS];

  // Set address wraps modulo 2^ADDR_W, which plain ADDR_W-wide arithmetic gives for free.
  assign tag_addr = TAG_BASE + ADDR_W'(f_index) * ADDR_W'(SET_BYTES);

  assign desc = {seq_q, grant_wr, sel_id, f_tag, f_index, f_offset};

  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    wren_d    = 1'b0;
    data_d    = data_q;
    seq_d     = seq_q;

    if (accept) begin
      arvalid_d = 1'b1;
      arid_d    = seq_q;
      araddr_d  = tag_addr;
      wren_d    = 1'b1;
      data_d    = desc;
      seq_d     = seq_q + SEQ_W'(1);
    end else if (bus.arready_i) begin
      arvalid_d = 1'b0;
    end
  end

  // NOTE: the datapath registers are reset too, because the outputs they drive must
  // read as zero out of reset, not just the valid/wren qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      wren_q    <= 1'b0;
      data_q    <= '0;
      seq_q     <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      wren_q    <= wren_d;
      data_q    <= data_d;
      seq_q     <= seq_d;
    end
  end

  assign bus.arvalid_o       = arvalid_q;
  assign bus.arid_o          = arid_q;
  assign bus.araddr_o        = araddr_q;
  assign bus.tag_fifo_wren_o = wren_q;
  assign bus.tag_fifo_data_o = data_q;

endmodule

// File: tb/tb_dc_index_extractor_arb.sv
// Bench for dc_index_extractor_arb: one read-priority instance and one round-robin instance
// with a wrapping tag base, both compared every cycle against a transaction-level model.
module tb_dc_index_extractor_arb;
  import dc_pkg::*;

  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE1 = 64'hFFFF_FFFF_FFF0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dc_index_extractor_arb_if if0 ();
  dc_index_extractor_arb_if if1 ();

  dc_index_extractor_arb #(.ARB_MODE(1'b0), .TAG_BASE(BASE0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  dc_index_extractor_arb #(.ARB_MODE(1'b1), .TAG_BASE(BASE1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  typedef struct packed {
    logic        vld;
    logic [7:0]  id;
    logic [63:0] addr;
    logic        wren;
    dc_desc_t    data;
    logic [7:0]  seq;
    logic        favour_wr;
  } mstate_t;

  typedef struct packed {
    logic        rdy_r;
    logic        rdy_w;
    logic        vld;
    logic [7:0]  id;
    logic [63:0] addr;
    logic        wren;
    dc_desc_t    data;
  } view_t;

  int n_cmp = 0;
  int n_err = 0;
  mstate_t m0, m1;

  // Which side the rules say is accepted this cycle: {read, write}.
  function automatic logic [1:0] model_rdy(mstate_t m, bit rr, logic arv, logic awv,
                                           logic ar_rdy, logic afull);
    bit can;
    can = (!m.vld || ar_rdy) && !afull;
    if (!can) return 2'b00;
    if (arv && awv) return (rr && m.favour_wr) ? 2'b01 : 2'b10;
    return {arv, awv};
  endfunction

  function automatic mstate_t model_next(mstate_t m, bit rr, logic [63:0] base,
                                         logic arv, logic [15:0] arid, logic [63:0] araddr,
                                         logic awv, logic [15:0] awid, logic [63:0] awaddr,
                                         logic ar_rdy, logic afull);
    mstate_t n;
    logic [1:0] r;
    logic [63:0] a;
    dc_desc_t d;
    n = m;
    n.wren = 1'b0;
    r = model_rdy(m, rr, arv, awv, ar_rdy, afull);
    if (r != 2'b00) begin
      a        = r[0] ? awaddr : araddr;
      d.seq    = m.seq;
      d.is_wr  = r[0];
      d.id     = r[0] ? awid : arid;
      d.offset = 6'(a % 64);
      d.index  = 20'((a / 64) % (64'd1 << 20));
      d.tag    = 38'(a / (64'd1 << 26));
      n.vld    = 1'b1;
      n.id     = m.seq;
      n.addr   = base + 64'(d.index) * 64;
      n.wren   = 1'b1;
      n.data   = d;
      n.seq    = m.seq + 8'd1;
      if (arv && awv) n.favour_wr = r[1];
    end else if (ar_rdy) begin
      n.vld = 1'b0;
    end
    return n;
  endfunction

  function automatic view_t model_view(mstate_t m, logic [1:0] r);
    view_t v;
    v.rdy_r = r[1];
    v.rdy_w = r[0];
    v.vld   = m.vld;
    v.id    = m.vld ? m.id : 8'h0;
    v.addr  = m.vld ? m.addr : 64'h0;
    v.wren  = m.wren;
    v.data  = m.wren ? m.data : '0;
    return v;
  endfunction

  function automatic view_t exp0();
    return model_view(m0, model_rdy(m0, 1'b0, if0.arvalid_i, if0.awvalid_i,
                                    if0.arready_i, if0.tag_fifo_afull_i));
  endfunction

  function automatic view_t exp1();
    return model_view(m1, model_rdy(m1, 1'b1, if1.arvalid_i, if1.awvalid_i,
                                    if1.arready_i, if1.tag_fifo_afull_i));
  endfunction

  function automatic view_t raw0();
    return {if0.arready_o, if0.awready_o, if0.arvalid_o, if0.arid_o, if0.araddr_o,
            if0.tag_fifo_wren_o, if0.tag_fifo_data_o};
  endfunction

  function automatic view_t raw1();
    return {if1.arready_o, if1.awready_o, if1.arvalid_o, if1.arid_o, if1.araddr_o,
            if1.tag_fifo_wren_o, if1.tag_fifo_data_o};
  endfunction

  // Held id/address after release and stale descriptor data are don't-care.
  function automatic view_t mask(view_t o, view_t e);
    view_t v;
    v = o;
    if (!e.vld) begin
      v.id   = 8'h0;
      v.addr = 64'h0;
    end
    if (!e.wren) v.data = '0;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= model_next(m0, 1'b0, BASE0, if0.arvalid_i, if0.arid_i, if0.araddr_i,
                       if0.awvalid_i, if0.awid_i, if0.awaddr_i, if0.arready_i,
                       if0.tag_fifo_afull_i);
      m1 <= model_next(m1, 1'b1, BASE1, if1.arvalid_i, if1.arid_i, if1.araddr_i,
                       if1.awvalid_i, if1.awid_i, if1.awaddr_i, if1.arready_i,
                       if1.tag_fifo_afull_i);
    end
  end

  task automatic drive0(input logic arv, input logic [15:0] arid, input logic [63:0] araddr,
                        input logic awv, input logic [15:0] awid, input logic [63:0] awaddr,
                        input logic rdy, input logic afull);
    if0.arvalid_i = arv;  if0.arid_i = arid;  if0.araddr_i = araddr;
    if0.awvalid_i = awv;  if0.awid_i = awid;  if0.awaddr_i = awaddr;
    if0.arready_i = rdy;  if0.tag_fifo_afull_i = afull;
  endtask

  task automatic drive1(input logic arv, input logic [15:0] arid, input logic [63:0] araddr,
                        input logic awv, input logic [15:0] awid, input logic [63:0] awaddr,
                        input logic rdy, input logic afull);
    if1.arvalid_i = arv;  if1.arid_i = arid;  if1.araddr_i = araddr;
    if1.awvalid_i = awv;  if1.awid_i = awid;  if1.awaddr_i = awaddr;
    if1.arready_i = rdy;  if1.tag_fifo_afull_i = afull;
  endtask

  task automatic test_reset();
    view_t e, o;
    drive0(0, 0, 0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (raw0() !== view_t'(0)) begin
      n_err++; $display("FAIL reset_dut0 got=%h exp=0", raw0());
    end
    n_cmp++;
    if (raw1() !== view_t'(0)) begin
      n_err++; $display("FAIL reset_dut1 got=%h exp=0", raw1());
    end
    @(negedge clk); rst = 1'b0;
    drive0(1, 16'h0011, {$urandom, $urandom}, 0, 0, 0, 0, 0);
    drive1(1, 16'h0022, {$urandom, $urandom}, 0, 0, 0, 0, 0);
    #1;
    e = exp0(); o = mask(raw0(), e); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_accept got=%h exp=%h", o, e); end
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp0(); o = mask(raw0(), e); n_cmp++;
    if (o !== e || o.vld !== 1'b1) begin
      n_err++; $display("FAIL reset_held got=%h exp=%h", o, e);
    end
    // Assert reset between edges: outputs must clear without a clock.
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (raw0() !== view_t'(0) || raw1() !== view_t'(0)) begin
      n_err++; $display("FAIL reset_async got0=%h got1=%h exp=0", raw0(), raw1());
    end
    @(negedge clk); rst = 1'b0;
    drive0(1, 16'h0033, {$urandom, $urandom}, 0, 0, 0, 1, 0);
    #1;
    e = exp0(); o = mask(raw0(), e); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_again got=%h exp=%h", o, e); end
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++;
    if (if0.arid_o !== 8'd0 || if0.arvalid_o !== 1'b1 || if0.tag_fifo_wren_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_id got id=%h vld=%b wren=%b exp id=00 vld=1 wren=1",
               if0.arid_o, if0.arvalid_o, if0.tag_fifo_wren_o);
    end
  endtask

  task automatic test_single_read();
    view_t e, o;
    dc_desc_t d;
    @(negedge clk);
    drive0(1, 16'hABCD, 64'h1_2345_6780, 0, 0, 0, 1, 0);
    #1;
    n_cmp++;
    if (if0.arready_o !== 1'b1 || if0.awready_o !== 1'b0) begin
      n_err++; $display("FAIL single_ready got=%b%b exp=10", if0.arready_o, if0.awready_o);
    end
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    e = exp0(); o = mask(raw0(), e); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL single_model got=%h exp=%h", o, e); end
    d = dc_desc_t'(if0.tag_fifo_data_o);
    n_cmp++;
    if (if0.araddr_o !== 64'h0345_6780 || d.index !== 20'hD159E || d.tag !== 38'h48 ||
        d.offset !== 6'h0 || d.is_wr !== 1'b0 || d.id !== 16'hABCD) begin
      n_err++;
      $display("FAIL single_fields got addr=%h idx=%h tag=%h off=%h wr=%b id=%h exp addr=3456780 idx=d159e tag=48 off=0 wr=0 id=abcd",
               if0.araddr_o, d.index, d.tag, d.offset, d.is_wr, d.id);
    end
  endtask

  task automatic test_contention();
    view_t e, o;
    logic [1:0] pat [4];
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) drive1(1, 16'h0100 + 16'(i), {$urandom, $urandom},
                        1, 16'h0200 + 16'(i), {$urandom, $urandom}, 1, 0);
      else       drive1(0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      e = exp1(); o = mask(raw1(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", i, o, e); end
      if (i < 4) begin
        n_cmp++;
        if ({if1.arready_o, if1.awready_o} !== pat[i]) begin
          n_err++; $display("FAIL rr_grant cyc=%0d got=%b%b exp=%b", i,
                            if1.arready_o, if1.awready_o, pat[i]);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if (if1.arid_o !== 8'(i - 1)) begin
          n_err++; $display("FAIL rr_seq cyc=%0d got=%0d exp=%0d", i, if1.arid_o, i - 1);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive0(1, 16'h0300, {$urandom, $urandom}, 1, 16'h0400, 64'h40, 1, 0);
      else       drive0(0, 0, 0, 1, 16'h0400, 64'h40, 1, 0);
      #1;
      e = exp0(); o = mask(raw0(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL prio_model cyc=%0d got=%h exp=%h", i, o, e); end
      n_cmp++;
      if (if0.awready_o !== (i == 3)) begin
        n_err++; $display("FAIL prio_aw cyc=%0d got=%b exp=%b", i, if0.awready_o, i == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    view_t e, o;
    logic [7:0] h_id;
    logic [63:0] h_addr;
    @(negedge clk);
    drive0(1, 16'h0500, {$urandom, $urandom}, 0, 0, 0, 0, 0);
    @(negedge clk);
    h_id = if0.arid_o; h_addr = if0.araddr_o;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      drive0(1, 16'h0600, {$urandom, $urandom}, 1, 16'h0700, {$urandom, $urandom}, 0, 0);
      #1;
      e = exp0(); o = mask(raw0(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bp_model cyc=%0d got=%h exp=%h", i, o, e); end
      n_cmp++;
      if (if0.arid_o !== h_id || if0.araddr_o !== h_addr || if0.arvalid_o !== 1'b1 ||
          if0.arready_o !== 1'b0 || if0.awready_o !== 1'b0 || if0.tag_fifo_wren_o !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cyc=%0d got id=%h addr=%h vld=%b rdy=%b%b wren=%b exp id=%h addr=%h vld=1 rdy=00 wren=0",
                          i, if0.arid_o, if0.araddr_o, if0.arvalid_o, if0.arready_o,
                          if0.awready_o, if0.tag_fifo_wren_o, h_id, h_addr);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive0(1, 16'h0800, {$urandom, $urandom}, 1, 16'h0900, {$urandom, $urandom}, 1, 0);
      #1;
      e = exp0(); o = mask(raw0(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, o, e); end
      if (i > 0) begin
        n_cmp++;
        if (if0.arvalid_o !== 1'b1 || if0.tag_fifo_wren_o !== 1'b1) begin
          n_err++; $display("FAIL b2b_issue cyc=%0d got vld=%b wren=%b exp 1 1", i,
                            if0.arvalid_o, if0.tag_fifo_wren_o);
        end
      end
    end
  endtask

  task automatic test_afull();
    view_t e, o;
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive0(1, 16'h0A00, {$urandom, $urandom}, 1, 16'h0B00, {$urandom, $urandom}, 1, i < 3);
      #1;
      e = exp0(); o = mask(raw0(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL afull_model cyc=%0d got=%h exp=%h", i, o, e); end
      if (i < 3) begin
        n_cmp++;
        if (if0.arready_o !== 1'b0 || if0.awready_o !== 1'b0 ||
            (i > 0 && if0.tag_fifo_wren_o !== 1'b0)) begin
          n_err++; $display("FAIL afull_block cyc=%0d got rdy=%b%b wren=%b exp rdy=00 wren=0",
                            i, if0.arready_o, if0.awready_o, if0.tag_fifo_wren_o);
        end
      end else if (i == 3) begin
        n_cmp++;
        if (if0.arready_o !== 1'b1) begin
          n_err++; $display("FAIL afull_release got=%b exp=1", if0.arready_o);
        end
      end
    end
  endtask

  task automatic test_wrap();
    view_t e, o;
    logic [7:0] prev;
    bit have_prev;
    bit saw_wrap;
    logic arv, awv;
    dc_desc_t d;
    have_prev = 0; saw_wrap = 0; prev = 8'h0;
    for (int i = 0; i < 262; i++) begin
      @(negedge clk);
      arv = 1'($urandom_range(0, 1));
      awv = !arv || 1'($urandom_range(0, 1));
      if (i < 260) drive0(arv, 16'($urandom), {$urandom, $urandom},
                          awv, 16'($urandom), {$urandom, $urandom}, 1, 0);
      else         drive0(0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      e = exp0(); o = mask(raw0(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, o, e); end
      if (if0.tag_fifo_wren_o === 1'b1) begin
        d = dc_desc_t'(if0.tag_fifo_data_o);
        n_cmp++;
        if (d.seq !== if0.arid_o) begin
          n_err++; $display("FAIL wrap_order cyc=%0d got fifo_seq=%h exp arid=%h", i, d.seq, if0.arid_o);
        end
        if (have_prev && prev == 8'd255 && if0.arid_o == 8'd0) saw_wrap = 1;
        prev = if0.arid_o; have_prev = 1;
      end
    end
    n_cmp++;
    if (!saw_wrap) begin n_err++; $display("FAIL wrap_seen got=0 exp=1"); end
  endtask

  task automatic test_random();
    view_t e, o;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive0(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom},
             1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0);
      drive1(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom},
             1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0);
      #1;
      e = exp0(); o = mask(raw0(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rand0 cyc=%0d got=%h exp=%h", i, o, e); end
      e = exp1(); o = mask(raw1(), e); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rand1 cyc=%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_afull();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
